gp_register_file_v2: RTL and testbench

//  Parametrised general-purpose register file, successor to the 8x8 GPR block.

---
 rtl/gp_register_file_v2.sv | 145 ++++++++++++++
 tb/tb_gp_register_file_v2.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gp_register_file_v2.sv
// gp_register_file_v2
//   General-purpose register file with a shared tri-state bus port, two
//   registered ALU operand ports with same-edge write forwarding, and an ALU
//   write-back port that clears a per-register busy scoreboard.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   read_data             load data_bus into reg[input_select] at the edge
//   write_data            drive reg[output_select] onto data_bus (combinational)
//   input_select          bus-load destination
//   output_select         bus-drive source
//   data_bus              shared tri-state system bus
//   alu_a/b_select        operand source registers
//   alu_a/b_value         operand values, registered, write-first forwarded
//   alu_a/b_busy          busy bit of the operand register after the edge
//   lock_valid/select     mark a register busy (result outstanding)
//   wb_valid/ready        write-back handshake
//   wb_select/value       write-back destination and data
//
// Write-back handshake: a transfer happens on a rising edge where
//   wb_valid & wb_ready. wb_ready is low only while a bus load owns the array
//   write port (read_data & !write_data); during that stall the master holds
//   wb_valid, wb_select and wb_value stable. A transfer to register 0 (when
//   ZERO_REG=1) or to a select >= NUM_REGS still completes but drops the data.

module gp_register_file_v2 #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int ZERO_REG   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read_data,
  input  logic                  write_data,
  input  logic [ADDR_WIDTH-1:0] input_select,
  input  logic [ADDR_WIDTH-1:0] output_select,
  inout  wire  [DATA_WIDTH-1:0] data_bus,
  input  logic [ADDR_WIDTH-1:0] alu_a_select,
  input  logic [ADDR_WIDTH-1:0] alu_b_select,
  output logic [DATA_WIDTH-1:0] alu_a_value,
  output logic [DATA_WIDTH-1:0] alu_b_value,
  output logic                  alu_a_busy,
  output logic                  alu_b_busy,
  input  logic                  lock_valid,
  input  logic [ADDR_WIDTH-1:0] lock_select,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [ADDR_WIDTH-1:0] wb_select,
  input  logic [DATA_WIDTH-1:0] wb_value
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_d;

  logic                  bus_load;
  logic                  wb_fire;
  logic [DATA_WIDTH-1:0] bus_out;
  logic [DATA_WIDTH-1:0] alu_a_d;
  logic [DATA_WIDTH-1:0] alu_b_d;
  logic                  alu_a_busy_d;
  logic                  alu_b_busy_d;

  // Register 0 is a constant zero when ZERO_REG is set. Selects at or above
  // NUM_REGS never match a loop index below, so they read 0 and drop writes.
  function automatic logic slot_live(input int idx);
    return !(ZERO_REG != 0 && idx == 0);
  endfunction

  // Driving the bus blocks any load, so the bus never loops back into the array.
  assign bus_load = read_data & ~write_data;
  assign wb_ready = ~bus_load;
  assign wb_fire  = wb_valid & wb_ready;

  assign data_bus = (reset && write_data) ? bus_out : {DATA_WIDTH{1'bz}};

  // Next array and scoreboard state; bus load and write-back are mutually
  // exclusive, and a same-edge lock wins over the write-back clear.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (slot_live(i)) begin
        if (bus_load && int'(input_select) == i) begin
          regs_d[i] = data_bus;
        end
        if (wb_fire && int'(wb_select) == i) begin
          regs_d[i] = wb_value;
          busy_d[i] = 1'b0;
        end
        if (lock_valid && int'(lock_select) == i) begin
          busy_d[i] = 1'b1;
        end
      end
    end
  end

  // Bus drive reads current state; operand ports read post-edge state so a
  // write on the same edge is forwarded.
  always_comb begin
    bus_out      = '0;
    alu_a_d      = '0;
    alu_b_d      = '0;
    alu_a_busy_d = 1'b0;
    alu_b_busy_d = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (slot_live(i)) begin
        if (int'(output_select) == i) begin
          bus_out = regs_q[i];
        end
        if (int'(alu_a_select) == i) begin
          alu_a_d      = regs_d[i];
          alu_a_busy_d = busy_d[i];
        end
        if (int'(alu_b_select) == i) begin
          alu_b_d      = regs_d[i];
          alu_b_busy_d = busy_d[i];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q      <= '0;
      alu_a_value <= '0;
      alu_b_value <= '0;
      alu_a_busy  <= 1'b0;
      alu_b_busy  <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      busy_q      <= busy_d;
      alu_a_value <= alu_a_d;
      alu_b_value <= alu_b_d;
      alu_a_busy  <= alu_a_busy_d;
      alu_b_busy  <= alu_b_busy_d;
    end
  end

endmodule

// File: tb/tb_gp_register_file_v2.sv
module tb_gp_register_file_v2;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;

  // ---------------- shared stimulus ----------------
  logic       read_data, write_data, lock_valid, wb_valid;
  logic [2:0] input_select, output_select, alu_a_select, alu_b_select;
  logic [2:0] lock_select, wb_select;
  logic [7:0] wb_value;
  logic       tb_drv;
  logic [7:0] tb_val;

  // Undriven bus floats high through the pull, so Z reads as 8'hFF.
  tri1 [7:0] bus0;
  tri1 [7:0] bus1;
  assign bus0 = tb_drv ? tb_val : 8'bz;
  assign bus1 = tb_drv ? tb_val : 8'bz;

  logic [7:0] a0, b0, a1, b1;
  logic       ab0, bb0, ab1, bb1, rdy0, rdy1;

  // dut0: 8 registers, no zero register. dut1: 6 registers, register 0 is zero.
  gp_register_file_v2 #(.DATA_WIDTH(8), .NUM_REGS(8), .ADDR_WIDTH(3), .ZERO_REG(0)) dut0 (
    .clock(clock), .reset(reset), .read_data(read_data), .write_data(write_data),
    .input_select(input_select), .output_select(output_select), .data_bus(bus0),
    .alu_a_select(alu_a_select), .alu_b_select(alu_b_select),
    .alu_a_value(a0), .alu_b_value(b0), .alu_a_busy(ab0), .alu_b_busy(bb0),
    .lock_valid(lock_valid), .lock_select(lock_select),
    .wb_valid(wb_valid), .wb_ready(rdy0), .wb_select(wb_select), .wb_value(wb_value)
  );

  gp_register_file_v2 #(.DATA_WIDTH(8), .NUM_REGS(6), .ADDR_WIDTH(3), .ZERO_REG(1)) dut1 (
    .clock(clock), .reset(reset), .read_data(read_data), .write_data(write_data),
    .input_select(input_select), .output_select(output_select), .data_bus(bus1),
    .alu_a_select(alu_a_select), .alu_b_select(alu_b_select),
    .alu_a_value(a1), .alu_b_value(b1), .alu_a_busy(ab1), .alu_b_busy(bb1),
    .lock_valid(lock_valid), .lock_select(lock_select),
    .wb_valid(wb_valid), .wb_ready(rdy1), .wb_select(wb_select), .wb_value(wb_value)
  );

  // ---------------- vectors ----------------
  typedef struct {
    logic       rd, wr;
    logic [2:0] isel, osel;
    logic [7:0] bus;
    logic [2:0] asel, bsel;
    logic       lock;
    logic [2:0] lsel;
    logic       wbv;
    logic [2:0] wsel;
    logic [7:0] wbval;
    logic       e_rdy;
    logic [7:0] e_bus;
    logic [7:0] e_a;
    logic       e_ab;
    logic [7:0] e_b;
    logic       e_bb;
  } vec_t;

  vec_t tbl [9];

  // ---------------- reference model ----------------
  logic [7:0] m_reg  [2][8];
  logic       m_busy [2][8];
  int         m_nregs [2] = '{8, 6};
  int         m_zero  [2] = '{0, 1};

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic m_live(int k, int sel);
    return (sel < m_nregs[k]) && !(m_zero[k] != 0 && sel == 0);
  endfunction

  function automatic logic [7:0] m_rd(int k, int sel);
    return m_live(k, sel) ? m_reg[k][sel] : 8'h00;
  endfunction

  function automatic logic m_rd_busy(int k, int sel);
    return m_live(k, sel) ? m_busy[k][sel] : 1'b0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 8; r++) begin
        m_reg[k][r]  = 8'h00;
        m_busy[k][r] = 1'b0;
      end
  endtask

  // One clock edge of the register file, from the behavioural rules.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (read_data && !write_data) begin
        if (m_live(k, int'(input_select))) m_reg[k][input_select] = tb_val;
      end else if (wb_valid) begin
        if (m_live(k, int'(wb_select))) begin
          m_reg[k][wb_select]  = wb_value;
          m_busy[k][wb_select] = 1'b0;
        end
      end
      if (lock_valid && m_live(k, int'(lock_select))) m_busy[k][lock_select] = 1'b1;
    end
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d at %0t: got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  task automatic check_comb(int k, logic rdy, logic [7:0] bus);
    chk("wb_ready", k, 32'(rdy), 32'(!(read_data && !write_data)));
    if (write_data)      chk("bus_drive", k, 32'(bus), 32'(m_rd(k, int'(output_select))));
    else if (!read_data) chk("bus_z", k, 32'(bus), 32'h000000FF);
  endtask

  task automatic check_regd(int k, logic [7:0] a, logic [7:0] b, logic ab, logic bb);
    chk("alu_a_value", k, 32'(a),  32'(m_rd(k, int'(alu_a_select))));
    chk("alu_b_value", k, 32'(b),  32'(m_rd(k, int'(alu_b_select))));
    chk("alu_a_busy",  k, 32'(ab), 32'(m_rd_busy(k, int'(alu_a_select))));
    chk("alu_b_busy",  k, 32'(bb), 32'(m_rd_busy(k, int'(alu_b_select))));
  endtask

  // ---------------- driver tasks ----------------
  function automatic vec_t idle();
    vec_t v;
    v = '{default: '0};
    v.e_rdy = 1'b1;
    return v;
  endfunction

  task automatic apply(vec_t v);
    read_data     = v.rd;
    write_data    = v.wr;
    input_select  = v.isel;
    output_select = v.osel;
    tb_val        = v.bus;
    tb_drv        = v.rd && !v.wr;
    alu_a_select  = v.asel;
    alu_b_select  = v.bsel;
    lock_valid    = v.lock;
    lock_select   = v.lsel;
    wb_valid      = v.wbv;
    wb_select     = v.wsel;
    wb_value      = v.wbval;
  endtask

  // Inputs are already applied; checks combinational paths, then the edge.
  task automatic do_cycle();
    #2;
    check_comb(0, rdy0, bus0);
    check_comb(1, rdy1, bus1);
    @(posedge clock);
    model_step();
    #1;
    check_regd(0, a0, b0, ab0, bb0);
    check_regd(1, a1, b1, ab1, bb1);
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t v;
    logic       stalled;
    logic [7:0] r2_val;

    //          rd wr is os bus    as bs lk ls wv ws wbval  rdy ebus   ea    eab eb    ebb
    tbl[0] = '{1, 0, 3, 0, 8'hA5, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 0};
    tbl[1] = '{1, 0, 2, 0, 8'h3C, 3, 2, 0, 0, 1, 4, 8'h77, 0, 8'h00, 8'hA5, 0, 8'h3C, 0};
    tbl[2] = '{0, 0, 0, 0, 8'h00, 4, 2, 0, 0, 1, 4, 8'h77, 1, 8'h00, 8'h77, 0, 8'h3C, 0};
    tbl[3] = '{0, 0, 0, 0, 8'h00, 5, 4, 1, 5, 0, 0, 8'h00, 1, 8'h00, 8'h00, 1, 8'h77, 0};
    tbl[4] = '{0, 0, 0, 0, 8'h00, 5, 4, 1, 5, 1, 5, 8'h11, 1, 8'h00, 8'h11, 1, 8'h77, 0};
    tbl[5] = '{0, 0, 0, 0, 8'h00, 5, 3, 0, 0, 1, 5, 8'h11, 1, 8'h00, 8'h11, 0, 8'hA5, 0};
    tbl[6] = '{1, 1, 6, 3, 8'h00, 6, 3, 0, 0, 1, 6, 8'h5A, 1, 8'hA5, 8'h5A, 0, 8'hA5, 0};
    tbl[7] = '{1, 0, 1, 0, 8'hC3, 1, 5, 1, 1, 0, 0, 8'h00, 0, 8'h00, 8'hC3, 1, 8'h11, 0};
    tbl[8] = '{1, 0, 1, 0, 8'hE7, 1, 5, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'hE7, 1, 8'h11, 0};

    // Reset held low with the bus drive requested: bus stays Z, outputs 0.
    reset = 1'b0;
    v = idle();
    v.wr = 1'b1;
    v.osel = 3'd3;
    apply(v);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("reset_bus_z", 0, 32'(bus0), 32'h000000FF);
    chk("reset_bus_z", 1, 32'(bus1), 32'h000000FF);
    chk("reset_alu_a", 0, 32'(a0), 32'h0);
    chk("reset_alu_b", 0, 32'(b0), 32'h0);
    chk("reset_busy",  0, 32'({ab0, bb0, ab1, bb1}), 32'h0);
    chk("reset_alu_a", 1, 32'(a1), 32'h0);
    reset = 1'b1;

    // Directed table: loads, stalls, forwarding, scoreboard.
    for (int i = 0; i < 9; i++) begin
      apply(tbl[i]);
      #1;
      chk($sformatf("tbl%0d_ready", i), 0, 32'(rdy0), 32'(tbl[i].e_rdy));
      if (tbl[i].wr) chk($sformatf("tbl%0d_bus", i), 0, 32'(bus0), 32'(tbl[i].e_bus));
      do_cycle();
      chk($sformatf("tbl%0d_a", i),  0, 32'(a0),  32'(tbl[i].e_a));
      chk($sformatf("tbl%0d_ab", i), 0, 32'(ab0), 32'(tbl[i].e_ab));
      chk($sformatf("tbl%0d_b", i),  0, 32'(b0),  32'(tbl[i].e_b));
      chk($sformatf("tbl%0d_bb", i), 0, 32'(bb0), 32'(tbl[i].e_bb));
    end

    // Zero register: wb to r0 handshakes but is dropped; lock to r0 is dropped.
    v = idle();
    v.wbv = 1'b1; v.wsel = 3'd0; v.wbval = 8'hFF;
    v.lock = 1'b1; v.lsel = 3'd0; v.asel = 3'd0;
    apply(v);
    #1;
    chk("zero_wb_ready", 1, 32'(rdy1), 32'h1);
    do_cycle();
    chk("zero_read", 1, 32'(a1), 32'h0);
    chk("zero_busy", 1, 32'(ab1), 32'h0);

    // Out-of-range bus load on the 6-register instance.
    v = idle();
    v.rd = 1'b1; v.isel = 3'd7; v.bus = 8'h99; v.asel = 3'd7; v.bsel = 3'd6;
    apply(v);
    do_cycle();
    chk("oor_read_a", 1, 32'(a1), 32'h0);
    chk("oor_read_b", 1, 32'(b1), 32'h0);

    // Reset dropped during a write-back stall with the bus drive requested.
    v = idle();
    v.lock = 1'b1; v.lsel = 3'd2; v.asel = 3'd2;
    apply(v);
    do_cycle();
    chk("pre_reset_busy", 0, 32'(ab0), 32'h1);
    v = idle();
    v.rd = 1'b1; v.isel = 3'd2; v.bus = 8'h66;
    v.wbv = 1'b1; v.wsel = 3'd2; v.wbval = 8'h44; v.asel = 3'd2;
    apply(v);
    do_cycle();
    chk("pre_reset_load", 0, 32'(a0), 32'h66);
    v.wr = 1'b1; v.osel = 3'd2;
    apply(v);
    #2;
    chk("pre_reset_drive", 0, 32'(bus0), 32'h66);
    reset = 1'b0;
    model_reset();
    #1;
    chk("mid_reset_bus_z", 0, 32'(bus0), 32'h000000FF);
    chk("mid_reset_alu_a", 0, 32'(a0), 32'h0);
    chk("mid_reset_busy",  0, 32'(ab0), 32'h0);
    @(posedge clock);
    #1;
    chk("held_reset_bus_z", 0, 32'(bus0), 32'h000000FF);
    apply(idle());
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v = idle();
      v.asel = 3'(i);
      v.bsel = 3'(7 - i);
      apply(v);
      do_cycle();
      chk("post_reset_reg", 0, 32'({a0, b0}), 32'h0);
      chk("post_reset_busy", 0, 32'({ab0, bb0}), 32'h0);
    end

    // Randomized traffic against the model; a stalled write-back is held.
    stalled = 1'b0;
    v = idle();
    for (int c = 0; c < 400; c++) begin
      v.rd   = ($urandom_range(0, 2) == 0);
      v.wr   = ($urandom_range(0, 3) == 0);
      v.isel = 3'($urandom_range(0, 7));
      v.osel = 3'($urandom_range(0, 7));
      v.bus  = 8'($urandom_range(0, 254));
      v.asel = 3'($urandom_range(0, 7));
      v.bsel = 3'($urandom_range(0, 7));
      v.lock = ($urandom_range(0, 3) == 0);
      v.lsel = 3'($urandom_range(0, 7));
      if (!stalled) begin
        v.wbv   = ($urandom_range(0, 1) == 0);
        v.wsel  = 3'($urandom_range(0, 7));
        v.wbval = 8'($urandom_range(0, 255));
      end
      apply(v);
      stalled = v.wbv && v.rd && !v.wr;
      do_cycle();
    end
    r2_val = m_rd(0, 2);
    v = idle();
    v.asel = 3'd2;
    apply(v);
    do_cycle();
    chk("final_r2", 0, 32'(a0), 32'(r2_val));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
